iir_coeff_loader: RTL and testbench
===================================

# iir_coeff_loader

Coefficient programming master for the IIR notch filter's parallel coefficient port. It accepts individual coefficient writes over a valid/ready configuration handshake into shadow registers. On a commit request it waits for a quiet gap in the filter's sample stream, then drives a single-cycle parallel write of all coefficients. It reads the filter's coefficient readback, compares it against the shadow copy, and reports done or error. It sits between the configuration/register block and the IIR filter, driving that filter's `coeff_wr_en`/`coeff_in` and consuming its `coeff_out`.

## Interface
Parameters:
- `COEFF_WIDTH`, 20: signed coefficient width; matches the filter.
- `COEFF_DEPTH`, 5: coefficient count, ordered b0, b1, b2, a1, a2.
- `ADDR_WIDTH`, `$clog2(COEFF_DEPTH)` (3): config address width.
- `QUIET_CYCLES`, 4: consecutive sample-free cycles required before the write. Must be ≥1.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting for quiet. Must exceed `QUIET_CYCLES`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cfg_valid`, in, 1: config write request.
- `cfg_ready`, out, 1: loader accepts writes; high only in IDLE.
- `cfg_addr`, in, `ADDR_WIDTH`: coefficient index.
- `cfg_data`, in, `COEFF_WIDTH` signed: coefficient value.
- `cfg_commit`, in, 1: request to push the shadow set to the filter.
- `sample_valid`, in, 1: the filter's input-sample valid, monitored for quiescence.
- `coeff_wr_en`, out, 1: filter coefficient write strobe.
- `coeff_bus[COEFF_DEPTH]`, out, `COEFF_WIDTH` signed each: shadow registers, driven continuously to the filter's `coeff_in`.
- `coeff_rb[COEFF_DEPTH]`, in, `COEFF_WIDTH` signed each: the filter's `coeff_out` readback.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a commit completes, whether it passed or failed.
- `verify_err`, out, 1: readback mismatch on the last commit. Held until the next commit is accepted.
- `addr_err`, out, 1: one-cycle pulse when a write to `cfg_addr ≥ COEFF_DEPTH` is dropped.
- `timeout_err`, out, 1: one-cycle pulse when a commit is aborted because no quiet gap occurred.

## Operation
- **States:** IDLE, WAIT_QUIET, WRITE, VERIFY.
- **IDLE**
  - `cfg_ready`=1.
  - A write is accepted when `cfg_valid && cfg_ready`. If the address is valid, the value goes to `shadow[cfg_addr]`; otherwise it is dropped and `addr_err` pulses.
  - `cfg_commit`=1 moves the FSM to WAIT_QUIET and clears `verify_err`, `quiet_cnt` and `wait_cnt`.
  - When a write and a commit arrive in the same cycle, the write lands first and is included in the commit.
- **WAIT_QUIET**, evaluated at each edge:
  - If `sample_valid`=1, `quiet_cnt` is cleared; otherwise, if `quiet_cnt == QUIET_CYCLES-1`, go to WRITE; otherwise `quiet_cnt`++.
  - `wait_cnt`++ on every edge. If `wait_cnt == TIMEOUT_CYCLES-1` and the quiet condition is not met on that edge, go to IDLE and pulse `timeout_err`. The shadow registers are retained.
  - If quiet completion and timeout coincide, quiet completion wins.
- **WRITE:** `coeff_wr_en`=1 for exactly this one cycle. Next state is VERIFY.
- **VERIFY:** compare all `coeff_rb[i]` against `shadow[i]`. Any mismatch sets `verify_err`. Next state is IDLE, with `done` pulsing in the first IDLE cycle.
- **Ignored inputs:** `cfg_commit` outside IDLE is ignored. `cfg_valid` outside IDLE is not accepted; the requester holds it until `cfg_ready` returns.
- **Arithmetic:** values pass through bit-exact with no width change. Both counters are wide enough for `TIMEOUT_CYCLES` and never wrap.

## Timing
- **Reset values (all outputs):** `cfg_ready`=0 while `rst` is asserted, then 1 in IDLE after release. `coeff_wr_en`=0, `busy`=0, `done`=0, `verify_err`=0, `addr_err`=0, `timeout_err`=0. Shadow registers are all 0, so `coeff_bus` is all 0. All registered outputs are driven from flops.
- **Config write:** accepted at edge E. The new value is visible on `coeff_bus` after E. `addr_err` is high in the cycle after E.
- **Commit latency:** commit accepted at edge E0 with no samples in flight.
  - `coeff_wr_en` is high in the cycle after edge E(`QUIET_CYCLES`).
  - The filter latches at E(Q+1), VERIFY runs in the cycle after E(Q+1), and `done` is high in the cycle after E(Q+2).
  - With the default Q=4: `coeff_wr_en` is high after E4 and `done` is high after E6.
- **Sample interruption:** each `sample_valid` pulse in WAIT_QUIET restarts the quiet count. `coeff_wr_en` is never high in a cycle immediately preceded by `sample_valid`=1 within the last Q cycles.
- **`busy`:** rises the cycle after E0 and falls together with the `done` pulse.
- **Reset mid-operation:** `rst` forces IDLE asynchronously. `coeff_wr_en` drops immediately, shadows are cleared, and no `done` is generated.

## Test plan
- **Basic program:** write 0x37061, 0xC8F9F, 0x37061, 0xC8F9F, 0x2E0C3 to addresses 0–4, commit with `sample_valid`=0 and Q=4 → `coeff_wr_en` is high for one cycle, 4 edges after the commit; `done` pulses 2 cycles later; `verify_err`=0; the filter reads back the same five values.
- **Quiet restart:** commit, then pulse `sample_valid` at the 3rd WAIT_QUIET cycle → `coeff_wr_en` is delayed until 4 consecutive quiet edges after the pulse.
- **Timeout:** `TIMEOUT_CYCLES`=16, `sample_valid` held at 1 → `timeout_err` pulses after 16 cycles, no `coeff_wr_en`, `busy` returns to 0, shadows unchanged.
- **Bad address and same-cycle commit:**
  - Write addr 5 with 0x12345 → `addr_err` pulses, shadow unchanged, `cfg_ready` stays 1.
  - Write addr 2 = 0x5907C with `cfg_commit` in the same cycle → the value is written to the filter.
- **Readback mismatch:** force `coeff_rb[4]` to 0x00000 during VERIFY → `verify_err`=1 alongside the `done` pulse; `verify_err` is cleared by the next commit.
- **Reset mid-commit:** assert `rst` while in WRITE → `coeff_wr_en`=0 immediately; after release all outputs are at reset values and `cfg_ready`=1.

Source files
------------

// File: rtl/iir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : iir_coeff_loader
// Brief    : Shadows IIR coefficients, pushes them to the filter in a quiet
//            gap of the sample stream, then verifies the readback.
// Revision : 1.0
// ============================================================================
module iir_coeff_loader #(
    parameter int COEFF_WIDTH    = 20,
    parameter int COEFF_DEPTH    = 5,
    parameter int ADDR_WIDTH     = $clog2(COEFF_DEPTH),
    parameter int QUIET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ADDR_WIDTH-1:0]         cfg_addr,
    input  logic signed [COEFF_WIDTH-1:0] cfg_data,
    input  logic                          cfg_commit,
    input  logic                          sample_valid,
    output logic                          coeff_wr_en,
    output logic signed [COEFF_WIDTH-1:0] coeff_bus [COEFF_DEPTH],
    input  logic signed [COEFF_WIDTH-1:0] coeff_rb  [COEFF_DEPTH],
    output logic                          busy,
    output logic                          done,
    output logic                          verify_err,
    output logic                          addr_err,
    output logic                          timeout_err
);

    localparam int                    c_cnt_w      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]    c_quiet_last = c_cnt_w'(QUIET_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]    c_wait_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0]   c_depth      = (ADDR_WIDTH + 1)'(COEFF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_QUIET = 2'd1,
        S_WRITE      = 2'd2,
        S_VERIFY     = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [c_cnt_w-1:0]              r_quiet_cnt;
    logic [c_cnt_w-1:0]              w_quiet_next;
    logic [c_cnt_w-1:0]              r_wait_cnt;
    logic [c_cnt_w-1:0]              w_wait_next;
    logic signed [COEFF_WIDTH-1:0]   r_shadow [COEFF_DEPTH];

    logic r_cfg_ready;
    logic r_busy;
    logic r_wr_en;
    logic r_done;
    logic r_verify_err;
    logic r_addr_err;
    logic r_timeout_err;

    logic w_wr_accept;
    logic w_addr_bad;
    logic w_commit;
    logic w_quiet_done;
    logic w_timeout;
    logic w_mismatch;

    // cfg_ready is only ever high while in IDLE, so it doubles as the IDLE qualifier
    assign w_wr_accept = cfg_valid && r_cfg_ready;
    assign w_addr_bad  = {1'b0, cfg_addr} >= c_depth;

    always_comb begin
        w_state_next = r_state;
        w_quiet_next = r_quiet_cnt;
        w_wait_next  = r_wait_cnt;
        w_commit     = 1'b0;
        w_quiet_done = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cfg_ready && cfg_commit) begin
                    w_commit     = 1'b1;
                    w_state_next = S_WAIT_QUIET;
                    w_quiet_next = '0;
                    w_wait_next  = '0;
                end
            end
            S_WAIT_QUIET: begin
                w_wait_next = r_wait_cnt + 1'b1;
                if (sample_valid) begin
                    w_quiet_next = '0;
                end else if (r_quiet_cnt == c_quiet_last) begin
                    w_quiet_done = 1'b1;
                    w_state_next = S_WRITE;
                end else begin
                    w_quiet_next = r_quiet_cnt + 1'b1;
                end
                // A quiet gap completing on the last allowed edge still wins
                if (!w_quiet_done && (r_wait_cnt == c_wait_last)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE:  w_state_next = S_VERIFY;
            S_VERIFY: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mismatch = 1'b0;
        for (int i = 0; i < COEFF_DEPTH; i++) begin
            if (coeff_rb[i] != r_shadow[i]) begin
                w_mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_quiet_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_cfg_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_done        <= 1'b0;
            r_verify_err  <= 1'b0;
            r_addr_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_quiet_cnt   <= w_quiet_next;
            r_wait_cnt    <= w_wait_next;
            r_cfg_ready   <= (w_state_next == S_IDLE);
            r_busy        <= (w_state_next != S_IDLE);
            r_wr_en       <= (w_state_next == S_WRITE);
            r_done        <= (r_state == S_VERIFY);
            r_addr_err    <= w_wr_accept && w_addr_bad;
            r_timeout_err <= w_timeout;
            if (w_commit) begin
                r_verify_err <= 1'b0;
            end else if ((r_state == S_VERIFY) && w_mismatch) begin
                r_verify_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COEFF_DEPTH; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_accept && !w_addr_bad) begin
            for (int i = 0; i < COEFF_DEPTH; i++) begin
                if (cfg_addr == ADDR_WIDTH'(i)) begin
                    r_shadow[i] <= cfg_data;
                end
            end
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign busy        = r_busy;
    assign coeff_wr_en = r_wr_en;
    assign done        = r_done;
    assign verify_err  = r_verify_err;
    assign addr_err    = r_addr_err;
    assign timeout_err = r_timeout_err;
    assign coeff_bus   = r_shadow;

endmodule
`default_nettype wire

// File: tb/tb_iir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_coeff_loader
// Brief    : Directed + randomized bench for iir_coeff_loader with a filter
//            register model and a quiet-gap timing model.
// Revision : 1.0
// ============================================================================
module tb_iir_coeff_loader;

    localparam int W = 20;
    localparam int D = 5;
    localparam int Q = 4;
    localparam int T = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_addr;
    logic signed [W-1:0] cfg_data;
    logic                cfg_commit;
    logic                sample_valid;
    logic                coeff_wr_en;
    logic signed [W-1:0] coeff_bus [D];
    logic signed [W-1:0] coeff_rb  [D];
    logic                busy;
    logic                done;
    logic                verify_err;
    logic                addr_err;
    logic                timeout_err;

    logic signed [W-1:0] filt  [D];
    logic signed [W-1:0] model [D];
    bit                  corrupt;
    bit                  pat [1:T];
    int                  total = 0;
    int                  bad   = 0;

    iir_coeff_loader #(
        .COEFF_WIDTH   (W),
        .COEFF_DEPTH   (D),
        .ADDR_WIDTH    (3),
        .QUIET_CYCLES  (Q),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .sample_valid(sample_valid),
        .coeff_wr_en (coeff_wr_en),
        .coeff_bus   (coeff_bus),
        .coeff_rb    (coeff_rb),
        .busy        (busy),
        .done        (done),
        .verify_err  (verify_err),
        .addr_err    (addr_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Filter coefficient bank: latches the parallel bus on the write strobe
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) filt[i] <= '0;
        end else if (coeff_wr_en) begin
            for (int i = 0; i < D; i++) filt[i] <= coeff_bus[i];
        end
    end

    always_comb begin
        for (int i = 0; i < D; i++) begin
            coeff_rb[i] = (corrupt && i == 4) ? '0 : filt[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag);
        for (int i = 0; i < D; i++) chk(tag, coeff_bus[i], model[i]);
    endtask

    // Edge (1-based, after the commit) on which Q consecutive sample-free edges complete; 0 = never within T
    function automatic int quiet_edge();
        int run = 0;
        for (int j = 1; j <= T; j++) begin
            if (pat[j]) run = 0;
            else        run++;
            if (run == Q) return j;
        end
        return 0;
    endfunction

    task automatic do_write(input logic [2:0] a, input logic signed [W-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
        if (a < 3'd5) model[a] = d;
        chk("addr_err", addr_err, (a >= 3'd5));
        chk("wr_ready", cfg_ready, 1);
        chk_bus("wr_bus");
    endtask

    task automatic do_commit(input bit wr, input logic [2:0] a, input logic signed [W-1:0] d);
        int k;
        int last;
        bit exp_verr;
        logic signed [W-1:0] rb_exp;
        k = quiet_edge();
        cfg_valid    = wr;
        cfg_addr     = a;
        cfg_data     = d;
        cfg_commit   = 1'b1;
        sample_valid = 1'b0;
        tick();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        if (wr && a < 3'd5) model[a] = d;
        chk("commit_busy", busy, 1);
        chk("commit_ready", cfg_ready, 0);
        chk("commit_verr_clr", verify_err, 0);
        last = (k == 0) ? T : k;
        for (int j = 1; j <= last; j++) begin
            sample_valid = pat[j];
            tick();
            chk("wr_en", coeff_wr_en, (j == k));
            chk("timeout_err", timeout_err, (k == 0 && j == last));
        end
        sample_valid = 1'b0;
        if (k == 0) begin
            chk("to_busy", busy, 0);
            chk("to_ready", cfg_ready, 1);
            tick();
            chk("to_pulse_end", timeout_err, 0);
            chk("to_done", done, 0);
            chk_bus("to_bus_kept");
            return;
        end
        tick();
        chk("verify_wr_en", coeff_wr_en, 0);
        chk("verify_busy", busy, 1);
        chk("verify_done", done, 0);
        exp_verr = 1'b0;
        for (int i = 0; i < D; i++) begin
            rb_exp = (corrupt && i == 4) ? '0 : model[i];
            if (rb_exp != model[i]) exp_verr = 1'b1;
        end
        tick();
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", cfg_ready, 1);
        chk("verify_err", verify_err, exp_verr);
        for (int i = 0; i < D; i++) chk("filter_rb", filt[i], model[i]);
        tick();
        chk("done_pulse_end", done, 0);
        chk("verify_err_hold", verify_err, exp_verr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [W-1:0] rv;
        int                  kk;
        rst = 1'b0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        cfg_commit = 1'b0; sample_valid = 1'b0; corrupt = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        for (int j = 1; j <= T; j++) pat[j] = 1'b0;
        #1 rst = 1'b1;
        #3;
        chk("rst_ready", cfg_ready, 0);
        chk("rst_wr_en", coeff_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_verr", verify_err, 0);
        chk("rst_aerr", addr_err, 0);
        chk("rst_terr", timeout_err, 0);
        chk_bus("rst_bus");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        chk("rel_ready_pre", cfg_ready, 0);
        tick();
        chk("rel_ready", cfg_ready, 1);

        // Basic program
        do_write(3'd0, 20'h37061);
        do_write(3'd1, 20'hC8F9F);
        do_write(3'd2, 20'h37061);
        do_write(3'd3, 20'hC8F9F);
        do_write(3'd4, 20'h2E0C3);
        do_commit(1'b0, 3'd0, '0);

        // Quiet restart: sample in the 3rd WAIT_QUIET cycle
        pat[3] = 1'b1;
        do_commit(1'b0, 3'd0, '0);
        pat[3] = 1'b0;

        // Timeout with samples never stopping
        for (int j = 1; j <= T; j++) pat[j] = 1'b1;
        do_write(3'd1, 20'h0ABCD);
        do_commit(1'b0, 3'd0, '0);
        for (int j = 1; j <= T; j++) pat[j] = 1'b0;

        // Bad address, then write+commit in the same cycle
        do_write(3'd5, 20'h12345);
        tick();
        chk("aerr_pulse_end", addr_err, 0);
        do_commit(1'b1, 3'd2, 20'h5907C);

        // Readback mismatch, then the next commit clears it
        rv = W'($urandom) | 20'sd1;
        do_write(3'd4, rv);
        corrupt = 1'b1;
        do_commit(1'b0, 3'd0, '0);
        corrupt = 1'b0;
        do_commit(1'b0, 3'd0, '0);

        // Randomized writes (including out-of-range addresses) and sample patterns
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < 4; n++) begin
                do_write(3'($urandom_range(0, 7)), W'($urandom));
            end
            for (int j = 1; j <= T; j++) pat[j] = ($urandom_range(0, 99) < 35);
            do_commit(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom));
        end
        for (int j = 1; j <= T; j++) pat[j] = 1'b0;

        // Reset while the write strobe is high
        kk = quiet_edge();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        repeat (kk) tick();
        chk("pre_rst_wr_en", coeff_wr_en, 1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < D; i++) model[i] = '0;
        chk("mid_rst_wr_en", coeff_wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cfg_ready, 0);
        chk_bus("mid_rst_bus");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", cfg_ready, 1);
        chk("post_rst_done", done, 0);
        chk("post_rst_wr_en", coeff_wr_en, 0);
        chk("post_rst_verr", verify_err, 0);
        tick();
        chk("post_rst_done2", done, 0);
        chk_bus("post_rst_bus");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
